// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//    Shares one external combinational ALU between two requesters. A request
//    is accepted with a valid/ready handshake, granted round-robin when both
//    requesters compete, executed for one cycle against the ALU, and its
//    result is held in a response register until the consumer takes it.
//
//    Sequence per operation: IDLE (grant) -> EXEC (ALU evaluates) -> RESP.
//    Peak throughput is one operation every three cycles.
//
// Ports:
//    clk                 clock, all state changes on the rising edge
//    rst_n               asynchronous active-low reset
//    i_req_valid[1:0]    bit i: requester i presents an operation
//    o_req_ready[1:0]    bit i: requester i's operation is accepted this cycle
//    i_req_opd1..4       slice [i*W +: W]: operands of requester i
//    i_req_mux1_sel[1:0] bit i: compare-operand select of requester i
//    i_req_mux2_sel[3:0] [2i+1:2i]: result select of requester i
//    i_req_op[7:0]       [4i+3:4i]: ALU op of requester i
//    o_alu_opd1..4       operands driven to the ALU (from operation register)
//    o_alu_mux1_select   compare-operand select driven to the ALU
//    o_alu_mux2_select   result select driven to the ALU
//    o_alu_op_select     op select driven to the ALU
//    i_alu_result        ALU result for the driven operation
//    i_comp_result       ALU zero-extended compare result
//    o_rsp_valid         response available
//    i_rsp_ready         consumer accepts the response
//    o_rsp_id            requester that owns the response
//    o_rsp_result        captured ALU result
//    o_rsp_comp          captured compare result
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int OPERAND_LENGTH = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,

   input  logic [1:0]                    i_req_valid,
   output logic [1:0]                    o_req_ready,
   input  logic [2*OPERAND_LENGTH-1:0]   i_req_opd1,
   input  logic [2*OPERAND_LENGTH-1:0]   i_req_opd2,
   input  logic [2*OPERAND_LENGTH-1:0]   i_req_opd3,
   input  logic [2*OPERAND_LENGTH-1:0]   i_req_opd4,
   input  logic [1:0]                    i_req_mux1_sel,
   input  logic [3:0]                    i_req_mux2_sel,
   input  logic [7:0]                    i_req_op,

   output logic [OPERAND_LENGTH-1:0]     o_alu_opd1,
   output logic [OPERAND_LENGTH-1:0]     o_alu_opd2,
   output logic [OPERAND_LENGTH-1:0]     o_alu_opd3,
   output logic [OPERAND_LENGTH-1:0]     o_alu_opd4,
   output logic                          o_alu_mux1_select,
   output logic [1:0]                    o_alu_mux2_select,
   output logic [3:0]                    o_alu_op_select,
   input  logic [OPERAND_LENGTH-1:0]     i_alu_result,
   input  logic [OPERAND_LENGTH-1:0]     i_comp_result,

   output logic                          o_rsp_valid,
   input  logic                          i_rsp_ready,
   output logic                          o_rsp_id,
   output logic [OPERAND_LENGTH-1:0]     o_rsp_result,
   output logic [OPERAND_LENGTH-1:0]     o_rsp_comp
);

   localparam int W = OPERAND_LENGTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Per-requester views of the packed request buses
   // ------------------------------------------------------------------------
   logic [W-1:0] w_opd1     [2];
   logic [W-1:0] w_opd2     [2];
   logic [W-1:0] w_opd3     [2];
   logic [W-1:0] w_opd4     [2];
   logic         w_mux1_sel [2];
   logic [1:0]   w_mux2_sel [2];
   logic [3:0]   w_op       [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_unpack
         assign w_opd1[gi]     = i_req_opd1[gi*W +: W];
         assign w_opd2[gi]     = i_req_opd2[gi*W +: W];
         assign w_opd3[gi]     = i_req_opd3[gi*W +: W];
         assign w_opd4[gi]     = i_req_opd4[gi*W +: W];
         assign w_mux1_sel[gi] = i_req_mux1_sel[gi];
         assign w_mux2_sel[gi] = i_req_mux2_sel[2*gi +: 2];
         assign w_op[gi]       = i_req_op[4*gi +: 4];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // State and registers
   // ------------------------------------------------------------------------
   state_t       r_state;
   logic         r_last_grant;

   // Operation register: the only source of the alu_* outputs.
   logic [W-1:0] r_op_opd1;
   logic [W-1:0] r_op_opd2;
   logic [W-1:0] r_op_opd3;
   logic [W-1:0] r_op_opd4;
   logic         r_op_mux1_sel;
   logic [1:0]   r_op_mux2_sel;
   logic [3:0]   r_op_code;
   logic         r_op_id;

   // Response register.
   logic         r_rsp_valid;
   logic         r_rsp_id;
   logic [W-1:0] r_rsp_result;
   logic [W-1:0] r_rsp_comp;

   // ------------------------------------------------------------------------
   // Grant decision (IDLE only)
   // ------------------------------------------------------------------------
   logic       w_grant;
   logic       w_grant_id;
   logic [1:0] w_ready;

   always_comb begin
      w_grant    = 1'b0;
      w_grant_id = 1'b0;
      if (r_state == S_IDLE) begin
         case (i_req_valid)
            2'b01: begin
               w_grant    = 1'b1;
               w_grant_id = 1'b0;
            end
            2'b10: begin
               w_grant    = 1'b1;
               w_grant_id = 1'b1;
            end
            2'b11: begin
               // Contention: the requester that did not win last time.
               w_grant    = 1'b1;
               w_grant_id = ~r_last_grant;
            end
            default: begin
               w_grant    = 1'b0;
               w_grant_id = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      w_ready = 2'b00;
      if (w_grant) begin
         w_ready[w_grant_id] = 1'b1;
      end
   end

   // The state register already reads IDLE while reset is held, so ready is
   // explicitly masked to keep requesters from seeing an acceptance that the
   // flops will not act on.
   assign o_req_ready = rst_n ? w_ready : 2'b00;

   // ------------------------------------------------------------------------
   // FSM with registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_last_grant  <= 1'b1;   // requester 0 wins the first contention
         r_op_opd1     <= '0;
         r_op_opd2     <= '0;
         r_op_opd3     <= '0;
         r_op_opd4     <= '0;
         r_op_mux1_sel <= 1'b0;
         r_op_mux2_sel <= 2'b00;
         r_op_code     <= 4'h0;
         r_op_id       <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_id      <= 1'b0;
         r_rsp_result  <= '0;
         r_rsp_comp    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_op_opd1     <= w_opd1[w_grant_id];
                  r_op_opd2     <= w_opd2[w_grant_id];
                  r_op_opd3     <= w_opd3[w_grant_id];
                  r_op_opd4     <= w_opd4[w_grant_id];
                  r_op_mux1_sel <= w_mux1_sel[w_grant_id];
                  r_op_mux2_sel <= w_mux2_sel[w_grant_id];
                  r_op_code     <= w_op[w_grant_id];
                  r_op_id       <= w_grant_id;
                  r_last_grant  <= w_grant_id;
                  r_state       <= S_EXEC;
               end
            end

            S_EXEC: begin
               // The ALU has seen the operation register for a full cycle.
               r_rsp_result <= i_alu_result;
               r_rsp_comp   <= i_comp_result;
               r_rsp_id     <= r_op_id;
               r_rsp_valid  <= 1'b1;
               r_state      <= S_RESP;
            end

            S_RESP: begin
               if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end

            default: begin
               r_rsp_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign o_alu_opd1        = r_op_opd1;
   assign o_alu_opd2        = r_op_opd2;
   assign o_alu_opd3        = r_op_opd3;
   assign o_alu_opd4        = r_op_opd4;
   assign o_alu_mux1_select = r_op_mux1_sel;
   assign o_alu_mux2_select = r_op_mux2_sel;
   assign o_alu_op_select   = r_op_code;

   assign o_rsp_valid  = r_rsp_valid;
   assign o_rsp_id     = r_rsp_id;
   assign o_rsp_result = r_rsp_result;
   assign o_rsp_comp   = r_rsp_comp;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Purpose: shares one combinational ALU between two requesters (index 0, 1), with valid/ready handshakes, round-robin grant and a registered response.

Interface
REQ-001 Parameter: OPERAND_LENGTH, default 32, width W of every operand and result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  2  bit i: requester i presents an operation.
REQ-005 req_ready  output  2  bit i: requester i's operation is accepted this cycle.
REQ-006 req_opd1  input  2W  slice [i*W +: W]: operand 1 of requester i.
REQ-007 req_opd2  input  2W  operand 2, same packing.
REQ-008 req_opd3  input  2W  operand 3 (compare-path alternate), same packing.
REQ-009 req_opd4  input  2W  operand 4 (compare-path alternate), same packing.
REQ-010 req_mux1_sel  input  2  bit i: compare-operand select of requester i.
REQ-011 req_mux2_sel  input  4  [2i+1:2i]: result-select of requester i.
REQ-012 req_op  input  8  [4i+3:4i]: 4-bit ALU op select of requester i.
REQ-013 alu_opd1, alu_opd2, alu_opd3, alu_opd4  output  W each  operands driven to the ALU.
REQ-014 alu_mux1_select / alu_mux2_select / alu_op_select  output  1 / 2 / 4  ALU controls.
REQ-015 alu_result  input  W  ALU result for the driven operation.
REQ-016 comp_result  input  W  ALU zero-extended compare result.
REQ-017 rsp_valid  output  1  response available.
REQ-018 rsp_ready  input  1  consumer accepts the response.
REQ-019 rsp_id  output  1  index of the requester that owns the response.
REQ-020 rsp_result / rsp_comp  output  W each  captured alu_result / comp_result.

Function
REQ-021 FSM states: IDLE, EXEC, RESP; exactly one is active per cycle.
REQ-022 IDLE, no req_valid bit set: remain in IDLE and hold req_ready = 2'b00.
REQ-023 IDLE, exactly one req_valid bit set: grant that requester.
REQ-024 IDLE, both req_valid bits set: grant the requester not recorded in last_grant.
REQ-025 Grant cycle: set req_ready bit of the winner only (combinational from state and req_valid); latch its operands, selects and op into an operation register; update last_grant; go to EXEC.
REQ-026 req_ready is 2'b00 in EXEC and RESP; requests that arrive there wait, are not dropped and are not acknowledged.
REQ-027 EXEC: alu_* outputs reflect the operation register; capture alu_result and comp_result into rsp_result and rsp_comp, set rsp_id to the granted index, go to RESP.
REQ-028 alu_* outputs are driven only from the operation register; they hold their last value outside EXEC and never pass request inputs through combinationally.
REQ-029 RESP: rsp_valid = 1; rsp_result, rsp_comp and rsp_id stay stable until the handshake completes.
REQ-030 RESP with rsp_ready = 1: the response completes and the FSM returns to IDLE; a new grant can occur in the following cycle.
REQ-031 RESP with rsp_ready = 0: remain in RESP indefinitely (backpressure).
REQ-032 Latency: accept at edge T, EXEC in cycle T+1, rsp_valid = 1 in cycle T+2; peak throughput is one operation per 3 cycles.
REQ-033 If req_valid drops in IDLE without a handshake, nothing is captured and last_grant is unchanged.

Reset
REQ-034 While rst_n = 0, asynchronously: state = IDLE; req_ready = 0; rsp_valid = 0; rsp_id = 0; rsp_result, rsp_comp, the operation register and all alu_* outputs = 0; last_grant = 1, so requester 0 wins the first contention.
REQ-035 Reset asserted in EXEC or RESP aborts the operation; its response is never presented after reset releases.

Verification (ALU replaced by a stub: alu_result = opd1 ^ opd2, comp_result = {W-1 zeros, opd1 < opd2})
REQ-036 Single request: req_valid = 2'b01, opd1 = 0x0F, opd2 = 0xF0, op = 4'h3 -> req_ready = 2'b01 for one cycle; alu_op_select = 4'h3 in EXEC; rsp_valid two cycles after accept with rsp_result = 0xFF, rsp_comp = 1, rsp_id = 0.
REQ-037 Contention: both valid and held from reset -> grants in order 0, 1, 0, 1; rsp_id follows the same order.
REQ-038 Backpressure: rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_result stay stable; req_ready stays 2'b00 throughout; completion on the first cycle with rsp_ready = 1.
REQ-039 Request arrives during EXEC: req_valid[1] rises in EXEC -> no req_ready until IDLE; then granted with its latched opd values, and its response is correct.
REQ-040 Mid-operation reset: rst_n pulsed low in RESP -> all outputs 0 immediately; after release, a fresh request to requester 1 with opd1 = 5, opd2 = 3 gives rsp_result = 6, rsp_comp = 0, rsp_id = 1.
